// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_t : FSM state encoding (binary)
//   len_w() : width of a field that must hold 0..pat_w (the pat_len port)
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/data bundle of seq_pattern_gen.
//   master : drives start, abort, pattern, pat_len, repeat_n, gap
//   slave  : drives dout, dvalid, busy, done
interface seq_pattern_gen_if
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  localparam int LEN_W = len_w(PAT_W);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] repeat_n;
  logic [CNT_W-1:0] gap;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, pat_len, repeat_n, gap,
    input  dout, dvalid, busy, done
  );

  modport slave (
    input  start, abort, pattern, pat_len, repeat_n, gap,
    output dout, dvalid, busy, done
  );

endinterface

// File: rtl/seq_gen_shreg.sv
// PAT_W-bit shift register for the pattern generator.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   load  : load pat left-aligned so bit [len-1] lands in the MSB
//   shift : shift left one bit, zero fill
//   pat   : parallel data
//   len   : number of valid bits in pat (1..PAT_W)
//   msb   : current MSB (registered)
// Bits above len are shifted out during alignment and the low end is
// zero-filled, so after len shifts the register is all zero. That keeps
// msb low between frames without extra gating.
module seq_gen_shreg #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             msb
);

  logic [PAT_W-1:0] sreg;
  logic [LEN_W-1:0] sh_amt;

  assign sh_amt = LEN_W'(PAT_W) - len;

  always_ff @(posedge clk) begin
    if (clr)        sreg <= '0;
    else if (load)  sreg <= pat << sh_amt;
    else if (shift) sreg <= {sreg[PAT_W-2:0], 1'b0};
  end

  assign msb = sreg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends pattern[pat_len-1:0] MSB first,
// repeat_n+1 times, with gap idle cycles between frames, then pulses done.
//   clk  : clock
//   rst  : synchronous reset, active high (beats abort and start)
//   bus  : seq_pattern_gen_if.slave
//          start/abort in, pattern/pat_len/repeat_n/gap in (captured at start),
//          dout/dvalid/busy/done out (all registered)
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.slave  bus
);

  localparam int LEN_W = len_w(PAT_W);

  state_t           state;
  logic [LEN_W-1:0] bit_cnt;   // bits left in current frame, incl. the one on dout
  logic [CNT_W-1:0] gap_cnt;   // gap cycles left, incl. current
  logic [CNT_W-1:0] frm_cnt;   // frames left after the current one
  logic [PAT_W-1:0] cap_pat;
  logic [LEN_W-1:0] cap_len;
  logic [CNT_W-1:0] cap_gap;
  logic             dvalid_q;
  logic             busy_q;
  logic             done_q;

  logic             len_ok;
  logic             accept;
  logic             kill;
  logic             last_bit;
  logic             reload;
  logic             sr_clr;
  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] ld_pat;
  logic [LEN_W-1:0] ld_len;
  logic             sr_msb;

  always_comb begin
    len_ok   = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(PAT_W));
    accept   = (state == S_IDLE) && bus.start && !bus.abort && len_ok;
    kill     = bus.abort && (state != S_IDLE);
    last_bit = (state == S_SEND) && (bit_cnt == LEN_W'(1));
    // Next frame starts either straight out of SEND (gap=0) or at the
    // final GAP cycle.
    reload   = (last_bit && (frm_cnt != '0) && (cap_gap == '0)) ||
               ((state == S_GAP) && (gap_cnt == CNT_W'(1)));
    sr_clr   = rst || kill;
    sr_load  = accept || reload;
    sr_shift = (state == S_SEND);
    // At accept the captured copies are not yet valid, so load from the bus.
    ld_pat   = (state == S_IDLE) ? bus.pattern : cap_pat;
    ld_len   = (state == S_IDLE) ? bus.pat_len : cap_len;
  end

  seq_gen_shreg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk   (clk),
    .clr   (sr_clr),
    .load  (sr_load),
    .shift (sr_shift),
    .pat   (ld_pat),
    .len   (ld_len),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      frm_cnt  <= '0;
      cap_pat  <= '0;
      cap_len  <= '0;
      cap_gap  <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (kill) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      frm_cnt  <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_pat  <= bus.pattern;
            cap_len  <= bus.pat_len;
            cap_gap  <= bus.gap;
            frm_cnt  <= bus.repeat_n;
            bit_cnt  <= bus.pat_len;
            state    <= S_SEND;
            dvalid_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_SEND: begin
          if (last_bit) begin
            if (frm_cnt != '0) begin
              frm_cnt <= frm_cnt - CNT_W'(1);
              if (cap_gap != '0) begin
                state    <= S_GAP;
                gap_cnt  <= cap_gap;
                dvalid_q <= 1'b0;
              end else begin
                bit_cnt <= cap_len;
              end
            end else begin
              state    <= S_DONE;
              dvalid_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - LEN_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == CNT_W'(1)) begin
            state    <= S_SEND;
            bit_cnt  <= cap_len;
            dvalid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout   = sr_msb;
  assign bus.dvalid = dvalid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen. Observed word per cycle is
// {dout, dvalid, busy, done}: E=send '1', 6=send '0', 2=gap, 3=done, 0=idle.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  seq_pattern_gen_if #(.PAT_W(8), .CNT_W(4)) bus ();

  seq_pattern_gen #(.PAT_W(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {bus.dout, bus.dvalid, bus.busy, bus.done};
  endfunction

  task automatic go(input logic [7:0] p, input logic [3:0] l,
                    input logic [3:0] r, input logic [3:0] g);
    bus.start = 1'b1; bus.pattern = p; bus.pat_len = l;
    bus.repeat_n = r; bus.gap = g;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1; bus.abort = 1'b0;
    bus.pattern = 8'hFF; bus.pat_len = 4'd4; bus.repeat_n = '0; bus.gap = '0;
    tick; tick;
    vecs++;
    if (obs() !== 4'h0) begin
      errs++; $display("FAIL reset got %h want 0", obs());
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick;
    vecs++;
    if (obs() !== 4'h0) begin
      errs++; $display("FAIL reset_release got %h want 0", obs());
    end
  endtask

  task automatic test_basic;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'h6, 4'hE, 4'hE, 4'h3, 4'h0};
    go(8'h0B, 4'd4, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL basic cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_repeat_gap;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'h6, 4'hE, 4'h2, 4'h2, 4'hE, 4'h6, 4'hE, 4'h2, 4'h2,
            4'hE, 4'h6, 4'hE, 4'h3, 4'h0, 4'h0};
    go(8'h05, 4'd3, 4'd2, 4'd2);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL repeat_gap cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_gap0;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'h6, 4'hE, 4'h6, 4'h3, 4'h0};
    go(8'h02, 4'd2, 4'd1, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL gap0 cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_full_len;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'hE, 4'h6, 4'h6, 4'h6, 4'h6, 4'hE, 4'hE, 4'h3, 4'h0};
    go(8'hC3, 4'd8, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL full_len cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_abort;
    logic [3:0] exp[$];
    // abort raised during the 2nd bit of a len-8 frame
    exp = '{4'hE, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    go(8'hA5, 4'd8, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      bus.abort = (i == 1);
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL abort cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
    bus.abort = 1'b0;
    exp = '{4'hE, 4'hE, 4'h3, 4'h0};
    go(8'h03, 4'd2, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL abort_restart cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_ignore;
    logic [3:0] exp[$];
    go(8'hFF, 4'd0, 4'd0, 4'd0);
    vecs++;
    if (obs() !== 4'h0) begin
      errs++; $display("FAIL len0_ignored got %h want 0", obs());
    end
    go(8'hFF, 4'd9, 4'd0, 4'd0);
    vecs++;
    if (obs() !== 4'h0) begin
      errs++; $display("FAIL len9_ignored got %h want 0", obs());
    end
    bus.abort = 1'b1;
    go(8'hFF, 4'd4, 4'd0, 4'd0);
    bus.abort = 1'b0;
    vecs++;
    if (obs() !== 4'h0) begin
      errs++; $display("FAIL abort_beats_start got %h want 0", obs());
    end
    // start held and inputs scrambled while busy: frame must not change
    exp = '{4'hE, 4'h6, 4'hE, 4'hE, 4'h3, 4'h0, 4'h0};
    go(8'h0B, 4'd4, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      if (i == 0) begin
        bus.start = 1'b1; bus.pattern = 8'hF0; bus.pat_len = 4'd2;
        bus.repeat_n = 4'd3; bus.gap = 4'd5;
      end
      if (i == 4) bus.start = 1'b0;
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL busy_start cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'h3, 4'h0, 4'hE, 4'h6, 4'h3, 4'h0};
    go(8'h01, 4'd1, 4'd0, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      // start raised in the idle cycle right after DONE
      if (i == 2) begin
        bus.start = 1'b1; bus.pattern = 8'h02; bus.pat_len = 4'd2;
        bus.repeat_n = 4'd0; bus.gap = 4'd0;
      end
      if (i == 3) bus.start = 1'b0;
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL back_to_back cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_max_repeat;
    logic [3:0] exp[$];
    exp = {};
    for (int i = 0; i < 16; i++) exp.push_back(4'hE);
    exp.push_back(4'h3);
    exp.push_back(4'h0);
    go(8'h01, 4'd1, 4'd15, 4'd0);
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL max_repeat cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_rst_gap;
    logic [3:0] exp[$];
    exp = '{4'hE, 4'h6, 4'hE, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    go(8'h05, 4'd3, 4'd1, 4'd3);
    for (int i = 0; i < exp.size(); i++) begin
      rst = (i == 4);
      vecs++;
      if (obs() !== exp[i]) begin
        errs++; $display("FAIL rst_gap cyc%0d got %h want %h", i, obs(), exp[i]);
      end
      tick;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_repeat_gap;
    test_gap0;
    test_full_len;
    test_abort;
    test_ignore;
    test_back_to_back;
    test_max_repeat;
    test_rst_gap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter: PAT_W, 8, maximum pattern length in bits (2..32).
REQ-002 Parameter: CNT_W, 4, width of the repeat and gap fields.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous reset, active-high.
REQ-005 Port: start  in  1  request to transmit; sampled only in IDLE.
REQ-006 Port: abort  in  1  synchronous cancel of the transfer in progress.
REQ-007 Port: pattern  in  PAT_W  bits to send; bit [pat_len-1] is sent first.
REQ-008 Port: pat_len  in  $clog2(PAT_W+1)  number of bits per frame; legal range 1..PAT_W.
REQ-009 Port: repeat_n  in  CNT_W  extra repetitions; total frames = repeat_n+1.
REQ-010 Port: gap  in  CNT_W  idle cycles inserted between frames.
REQ-011 Port: dout  out  1  serial data, registered.
REQ-012 Port: dvalid  out  1  high when dout carries a pattern bit, registered.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: done  out  1  one-cycle pulse after the last bit of the last frame.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and DONE, with one-hot or binary encoding taken from the shared package.
REQ-016 IDLE->SEND SHALL occur on the edge where start=1 and 1<=pat_len<=PAT_W; pattern, pat_len, repeat_n and gap are captured on that edge.
REQ-017 start with pat_len=0 or pat_len>PAT_W SHALL be ignored: the block stays in IDLE with no output activity.
REQ-018 Latency: if start is accepted at edge k, the first bit SHALL be on dout with dvalid=1 during cycle k+1.
REQ-019 SEND SHALL output one bit per cycle, MSB first from bit [pat_len-1] down to bit [0], for exactly pat_len cycles.
REQ-020 At the end of a frame with frames remaining: gap>0 SHALL go to GAP for exactly gap cycles, and gap=0 SHALL go back to SEND with no idle cycle.
REQ-021 GAP SHALL drive dout=0 and dvalid=0, then return to SEND and reload the captured pattern.
REQ-022 After the last bit of the final frame, the FSM SHALL enter DONE for one cycle (done=1, dvalid=0), then return to IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-024 Changes on pattern, pat_len, repeat_n or gap while busy SHALL NOT affect the transfer in progress.
REQ-025 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on that edge: dout=0, dvalid=0, busy=0 next cycle, and no done pulse.
REQ-026 If abort and start arrive together in IDLE, abort SHALL win and no transfer starts.
REQ-027 Frame count SHALL reach repeat_n+1 without overflow; repeat_n = 2^CNT_W-1 is legal.
REQ-028 Outside SEND, dout SHALL be 0.
REQ-029 start may be accepted in the cycle right after DONE (back-to-back transfers).

Reset
REQ-030 rst=1 SHALL force IDLE, dout=0, dvalid=0, busy=0, done=0, and clear all counters on the next edge; rst has priority over abort and start.
REQ-031 rst asserted mid-frame SHALL end the transfer with no done pulse.

Structure
REQ-032 The state encodings and the width function for pat_len SHALL live in package seq_gen_pkg.
REQ-033 Sub-module seq_gen_shreg SHALL provide the PAT_W-bit shift register: parallel load with alignment by pat_len, shift left, MSB output.
REQ-034 Bit, gap and frame counters SHALL stay in seq_pattern_gen.

Verification
REQ-035 Scenario: pattern=8'h0B, pat_len=4, repeat_n=0, gap=0, start at edge k -> dout 1,0,1,1 in cycles k+1..k+4 with dvalid=1, done=1 in cycle k+5, busy=0 in cycle k+6.
REQ-036 Scenario: pattern=8'h05, pat_len=3, repeat_n=2, gap=2 -> 101,00,101,00,101 with dvalid low during the gaps, then one done pulse.
REQ-037 Scenario: repeat_n=1, gap=0, pattern 2'b10 (pat_len=2) -> 1,0,1,0 with dvalid continuous for 4 cycles.
REQ-038 Scenario: abort in the 2nd bit of a pat_len=8 frame -> dvalid=0 and busy=0 next cycle, no done; a following start works normally.
REQ-039 Scenario: start with pat_len=0, then start while busy -> first is ignored; the second does not alter or restart the frame in progress.
REQ-040 Scenario: rst pulsed mid-GAP -> all outputs 0 next cycle, no done pulse.
